// File: rtl/elevator_ctrl_n.sv
// SCAN (collective) elevator controller for FLOORS floors with travel and door-dwell timing.
// Requests latch every clock; FSM, floor, direction and counters advance only when en=1.
module elevator_ctrl_n #(
   parameter int unsigned FLOORS     = 4,
   parameter int unsigned FW         = 2,
   parameter int unsigned TRAVEL_CYC = 4,
   parameter int unsigned DOOR_CYC   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [FLOORS-1:0] car_req,
   input  logic [FLOORS-1:0] hall_up,
   input  logic [FLOORS-1:0] hall_dn,
   output logic [FW-1:0]     piso,
   output logic [1:0]        accion,
   output logic              puertas,
   output logic [FLOORS-1:0] pending
);

   localparam int unsigned TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
   localparam int unsigned DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
   localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
   typedef enum logic [1:0] {D_NONE = 2'd0, D_UP = 2'd1, D_DOWN = 2'd2} dir_t;

   state_t            state, state_nx;
   dir_t              dir, dir_nx;
   logic [FW-1:0]     piso_nx, piso_mv, efloor;
   logic [TW-1:0]     tcnt, tcnt_nx;
   logic [DW-1:0]     dcnt, dcnt_nx;
   logic [1:0]        accion_nx;
   logic              puertas_nx;
   logic [FLOORS-1:0] car_p, up_p, dn_p, car_nx, up_nx, dn_nx;
   logic [FLOORS-1:0] car_in, up_in, dn_in;
   logic              hold, enter, above, below, here, stop, ab, bl;

   function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FW-1:0] n);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < FLOORS; i++)
         if (v[i] && (FW'(i) > n)) r = 1'b1;
      return r;
   endfunction

   function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FW-1:0] n);
      logic r;
      r = 1'b0;
      for (int unsigned i = 0; i < FLOORS; i++)
         if (v[i] && (FW'(i) < n)) r = 1'b1;
      return r;
   endfunction

   // Next-state, request latching and door-entry clearing
   always_comb begin
      state_nx   = state;
      dir_nx     = dir;
      piso_nx    = piso;
      tcnt_nx    = tcnt;
      dcnt_nx    = dcnt;
      accion_nx  = accion;
      puertas_nx = puertas;
      enter      = 1'b0;
      efloor     = piso;
      stop       = 1'b0;
      hold       = 1'b0;
      ab         = 1'b0;
      bl         = 1'b0;
      car_in     = car_req;
      up_in      = hall_up & UP_MASK;
      dn_in      = hall_dn & DN_MASK;
      above      = any_above(pending, piso);
      below      = any_below(pending, piso);
      here       = pending[piso];
      piso_mv    = (dir == D_DOWN) ? piso - FW'(1) : piso + FW'(1);

      // Buttons at the open-door floor extend the dwell instead of latching
      if (state == DOOR) begin
         hold = car_in[piso];
         car_in[piso] = 1'b0;
         if (dir != D_DOWN) begin
            hold = hold | up_in[piso];
            up_in[piso] = 1'b0;
         end
         if (dir != D_UP) begin
            hold = hold | dn_in[piso];
            dn_in[piso] = 1'b0;
         end
      end

      if (en) begin
         case (state)
            IDLE: begin
               if (here) begin
                  enter = 1'b1;
               end else if ((dir == D_UP && above) || (dir != D_DOWN && above)) begin
                  state_nx = MOVE; dir_nx = D_UP; accion_nx = 2'd1; tcnt_nx = '0;
               end else if (below) begin
                  state_nx = MOVE; dir_nx = D_DOWN; accion_nx = 2'd2; tcnt_nx = '0;
               end else if (above) begin
                  state_nx = MOVE; dir_nx = D_UP; accion_nx = 2'd1; tcnt_nx = '0;
               end else begin
                  dir_nx = D_NONE;
               end
            end
            MOVE: begin
               if (tcnt == TW'(TRAVEL_CYC - 1)) begin
                  tcnt_nx = '0;
                  piso_nx = piso_mv;
                  if (dir == D_DOWN)
                     stop = car_p[piso_mv] | dn_p[piso_mv] |
                            (up_p[piso_mv] & ~any_below(pending, piso_mv)) |
                            (piso_mv == '0);
                  else
                     stop = car_p[piso_mv] | up_p[piso_mv] |
                            (dn_p[piso_mv] & ~any_above(pending, piso_mv)) |
                            (piso_mv == FW'(FLOORS - 1));
                  if (stop) begin
                     enter  = 1'b1;
                     efloor = piso_mv;
                  end
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
            DOOR: begin
               if (hold) begin
                  dcnt_nx = '0;
               end else if (dcnt == DW'(DOOR_CYC - 1)) begin
                  state_nx = IDLE; puertas_nx = 1'b0; dcnt_nx = '0;
               end else begin
                  dcnt_nx = dcnt + DW'(1);
               end
            end
            default: state_nx = IDLE;
         endcase
      end

      car_nx = car_p | car_in;
      up_nx  = up_p | up_in;
      dn_nx  = dn_p | dn_in;

      // Door entry: serve the floor in the travel direction, drop dir if nothing ahead
      if (enter) begin
         state_nx   = DOOR;
         puertas_nx = 1'b1;
         accion_nx  = 2'd0;
         dcnt_nx    = '0;
         tcnt_nx    = '0;
         ab = any_above(pending, efloor);
         bl = any_below(pending, efloor);
         car_nx[efloor] = 1'b0;
         case (dir)
            D_UP: begin
               up_nx[efloor] = 1'b0;
               if (!ab) begin dn_nx[efloor] = 1'b0; dir_nx = D_NONE; end
            end
            D_DOWN: begin
               dn_nx[efloor] = 1'b0;
               if (!bl) begin up_nx[efloor] = 1'b0; dir_nx = D_NONE; end
            end
            default: begin
               up_nx[efloor] = 1'b0;
               dn_nx[efloor] = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         dir     <= D_NONE;
         piso    <= '0;
         tcnt    <= '0;
         dcnt    <= '0;
         accion  <= 2'd0;
         puertas <= 1'b0;
         car_p   <= '0;
         up_p    <= '0;
         dn_p    <= '0;
         pending <= '0;
      end else begin
         state   <= state_nx;
         dir     <= dir_nx;
         piso    <= piso_nx;
         tcnt    <= tcnt_nx;
         dcnt    <= dcnt_nx;
         accion  <= accion_nx;
         puertas <= puertas_nx;
         car_p   <= car_nx;
         up_p    <= up_nx;
         dn_p    <= dn_nx;
         pending <= car_nx | up_nx | dn_nx;
      end
   end

endmodule
